// File: rtl/core_pkg.sv
// Shared core definitions: data widths, the canonical NOP and the fetch-valid run-length helper.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned MAX_LANES = 4;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Lanes above the first invalid one are dropped, so only the low contiguous run counts.
    function automatic int unsigned lowest_run_len(input logic [MAX_LANES-1:0] valid);
        int unsigned len;
        logic        run;
        len = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            run = run & valid[i];
            if (run) len = len + 1;
        end
        return len;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch address register: advances by the number of accepted lanes, restarts word-aligned on redirect.
import core_pkg::*;

module fetch_pc_gen #(
    parameter int unsigned      LANES    = 2,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic [$clog2(LANES+1)-1:0]   enq_n,
    output logic [XLEN-1:0]              fetch_pc
);

    logic [XLEN-1:0] fetch_pc_d, fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q + (XLEN'(enq_n) << 2);
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/fetch_queue_n.sv
// Multi-lane instruction fetch queue: enqueues a contiguous run of fetched words per cycle
// and presents the oldest LANES entries to decode.
import core_pkg::*;

module fetch_queue_n #(
    parameter int unsigned      LANES    = 2,
    parameter int unsigned      DEPTH    = 8,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [LANES*XLEN-1:0]         pc_out,
    output logic                          fetch_req,
    input  logic [LANES*INST_W-1:0]       inst_in,
    input  logic [LANES-1:0]              inst_in_valid,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic [$clog2(LANES+1)-1:0]    deq_count,
    output logic [LANES*INST_W-1:0]       inst_out,
    output logic [LANES*XLEN-1:0]         pc_deq,
    output logic [LANES-1:0]              out_valid,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned DeqW = $clog2(LANES + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0]   mem_pc   [DEPTH];

    logic [PtrW-1:0]   wr_ptr_d, wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_d, rd_ptr_q;
    logic [CntW-1:0]   count_d, count_q;
    logic [CntW-1:0]   free_slots;
    logic [CntW-1:0]   deq_eff;
    logic [DeqW-1:0]   enq_n;
    logic [XLEN-1:0]   fetch_pc;
    logic [PtrW-1:0]   rd_idx [LANES];

    fetch_pc_gen #(
        .LANES    (LANES),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .enq_n       (enq_n),
        .fetch_pc    (fetch_pc)
    );

    // Free space is judged on the registered count, before this cycle's dequeue.
    always_comb begin
        free_slots = CntW'(DEPTH) - count_q;
        fetch_req  = !rst && !redirect && (free_slots >= CntW'(LANES));
        enq_n      = fetch_req ? DeqW'(lowest_run_len(MAX_LANES'(inst_in_valid))) : '0;
        deq_eff    = (CntW'(deq_count) < count_q) ? CntW'(deq_count) : count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(enq_n);
        rd_ptr_d = rd_ptr_q + PtrW'(deq_eff);
        count_d  = count_q + CntW'(enq_n) - deq_eff;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // enq_n is already zero under rst or redirect, so storage needs no extra gating.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(enq_n)) begin
                mem_inst[wr_ptr_q + PtrW'(k)] <= inst_in[k*INST_W +: INST_W];
                mem_pc[wr_ptr_q + PtrW'(k)]   <= fetch_pc + XLEN'(4 * k);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            rd_idx[i]                = rd_ptr_q + PtrW'(i);
            pc_out[i*XLEN +: XLEN]   = fetch_pc + XLEN'(4 * i);
            out_valid[i]             = count_q > CntW'(i);
            if (out_valid[i]) begin
                inst_out[i*INST_W +: INST_W] = mem_inst[rd_idx[i]];
                pc_deq[i*XLEN +: XLEN]       = mem_pc[rd_idx[i]];
            end else begin
                inst_out[i*INST_W +: INST_W] = NOP_INST;
                pc_deq[i*XLEN +: XLEN]       = '0;
            end
        end
    end

    assign count = count_q;

endmodule
